// File: rtl/sp_dram_word_port_if.sv
// Signal bundle between a kernel-side word requester, the word port adapter
// and the sp_dram line interface.
interface sp_dram_word_port_if #(
  parameter int ADDR_WIDTH = 27,
  parameter int WIDTH      = 32
);
  logic [ADDR_WIDTH-1:0] addr_in;
  logic [WIDTH-1:0]      din;
  logic                  we_in;
  logic                  re_in;
  logic                  ready_out;
  logic [WIDTH-1:0]      dout;
  logic                  dout_valid;
  logic [ADDR_WIDTH-3:0] mem_addr;
  logic [4*WIDTH-1:0]    mem_wdata;
  logic [15:0]           mem_mask;
  logic                  mem_we;
  logic                  mem_re;
  logic                  mem_full;
  logic [4*WIDTH-1:0]    mem_rdata;
  logic                  mem_ravail;

  // The adapter itself.
  modport slave (
    input  addr_in, din, we_in, re_in, mem_full, mem_rdata, mem_ravail,
    output ready_out, dout, dout_valid, mem_addr, mem_wdata, mem_mask, mem_we, mem_re
  );

  // Whatever surrounds the adapter: requester plus memory.
  modport master (
    output addr_in, din, we_in, re_in, mem_full, mem_rdata, mem_ravail,
    input  ready_out, dout, dout_valid, mem_addr, mem_wdata, mem_mask, mem_we, mem_re
  );
endinterface

// File: rtl/sp_dram_word_port.sv
// Single-word read/write adapter onto the 128-bit masked line interface of sp_dram.
// One request in flight; commands wait while sp_dram reports full.
module sp_dram_word_port #(
  parameter int ADDR_WIDTH = 27,
  parameter int WIDTH      = 32
) (
  input logic                clk,
  input logic                rst,
  sp_dram_word_port_if.slave bus
);

  typedef enum logic [1:0] {IDLE, WRITE, READ_REQ, READ_WAIT} state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [WIDTH-1:0]      din_q, din_d;
  logic [WIDTH-1:0]      dout_q, dout_d;
  logic                  dout_valid_q, dout_valid_d;
  logic                  mem_we_c, mem_re_c;
  logic [WIDTH-1:0]      lane_rdata [4];
  logic [15:0]           mask_c;
  logic [4*WIDTH-1:0]    wdata_c;

  // Per-lane slicing: write data is replicated, the mask opens only the addressed lane.
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    assign lane_rdata[gi]             = bus.mem_rdata[WIDTH*gi +: WIDTH];
    assign wdata_c[WIDTH*gi +: WIDTH] = din_q;
    assign mask_c[4*gi +: 4]          = {4{addr_q[1:0] == 2'(gi)}};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      din_q        <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      din_q        <= din_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    din_d        = din_q;
    dout_d       = dout_q;
    dout_valid_d = 1'b0;
    mem_we_c     = 1'b0;
    mem_re_c     = 1'b0;
    case (state_q)
      IDLE: begin
        // A simultaneous read strobe is dropped in favour of the write.
        if (bus.we_in) begin
          addr_d  = bus.addr_in;
          din_d   = bus.din;
          state_d = WRITE;
        end else if (bus.re_in) begin
          addr_d  = bus.addr_in;
          state_d = READ_REQ;
        end
      end
      WRITE: begin
        mem_we_c = !bus.mem_full;
        if (!bus.mem_full) state_d = IDLE;
      end
      READ_REQ: begin
        mem_re_c = !bus.mem_full;
        if (!bus.mem_full) state_d = READ_WAIT;
      end
      READ_WAIT: begin
        if (bus.mem_ravail) begin
          dout_d       = lane_rdata[addr_q[1:0]];
          dout_valid_d = 1'b1;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.ready_out  = (state_q == IDLE);
  assign bus.dout       = dout_q;
  assign bus.dout_valid = dout_valid_q;
  assign bus.mem_addr   = addr_q[ADDR_WIDTH-1:2];
  assign bus.mem_wdata  = wdata_c;
  assign bus.mem_mask   = mask_c;
  assign bus.mem_we     = mem_we_c;
  assign bus.mem_re     = mem_re_c;

endmodule

// File: tb/tb_sp_dram_word_port.sv
// Bench for sp_dram_word_port: vector table plus scoreboard of expected line
// commands and read data, with hand sequences for reset and strobe corner cases.
module tb_sp_dram_word_port;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sp_dram_word_port_if #(.ADDR_WIDTH(27), .WIDTH(32)) bus ();

  sp_dram_word_port #(.ADDR_WIDTH(27), .WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    bit          is_wr;
    logic [24:0] maddr;
    logic [15:0] mask;
    logic [31:0] data;
  } cmd_t;

  typedef struct {
    bit           is_wr;
    logic [26:0]  addr;
    logic [31:0]  data;
    logic [127:0] line;
    int           delay;
    int           nfull;
    logic [24:0]  exp_maddr;
    logic [15:0]  exp_mask;
    logic [31:0]  exp_dout;
  } vec_t;

  cmd_t        cmd_q[$];
  logic [31:0] rd_q[$];
  int          checks   = 0;
  int          failures = 0;
  int          n_we     = 0;
  int          n_re     = 0;
  vec_t        vecs[8];
  cmd_t        mon_c;
  logic [31:0] mon_d;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Scoreboard: pop on every command or read-data pulse the DUT produces.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.mem_we || bus.mem_re) begin
        chk("cmd_exclusive", {bus.mem_we, bus.mem_re}, (bus.mem_we ? 2'b10 : 2'b01));
        chk("cmd_while_full", bus.mem_full, 1'b0);
        if (bus.mem_we) n_we++;
        else n_re++;
        if (cmd_q.size() == 0) begin
          chk("unexpected_cmd", {bus.mem_we, bus.mem_re}, 2'b00);
        end else begin
          mon_c = cmd_q.pop_front();
          chk("cmd_kind_we", bus.mem_we, mon_c.is_wr);
          chk("cmd_addr", bus.mem_addr, mon_c.maddr);
          chk("cmd_mask", bus.mem_mask, mon_c.mask);
          if (mon_c.is_wr) chk("cmd_wdata", bus.mem_wdata, {4{mon_c.data}});
        end
      end
      if (bus.dout_valid) begin
        if (rd_q.size() == 0) begin
          chk("unexpected_dout_valid", bus.dout_valid, 1'b0);
        end else begin
          mon_d = rd_q.pop_front();
          chk("sb_dout", bus.dout, mon_d);
        end
      end
    end
  end

  task automatic wait_ready();
    int k = 0;
    while (!bus.ready_out && k < 50) begin
      @(posedge clk); #1;
      k++;
    end
    chk("ready_wait", bus.ready_out, 1'b1);
  endtask

  task automatic do_write(input logic [26:0] a, input logic [31:0] d, input logic [24:0] ema,
                          input logic [15:0] emask, input int nfull, input bit both);
    cmd_t c;
    int   w0 = n_we;
    int   r0 = n_re;
    c.is_wr = 1'b1; c.maddr = ema; c.mask = emask; c.data = d;
    cmd_q.push_back(c);
    chk("wr_ready_idle", bus.ready_out, 1'b1);
    bus.addr_in = a; bus.din = d; bus.we_in = 1'b1; bus.re_in = both;
    bus.mem_full = (nfull > 0);
    @(posedge clk); #1;
    bus.we_in = 1'b0; bus.re_in = 1'b0;
    for (int i = 0; i < nfull; i++) begin
      chk("bp_we_low", bus.mem_we, 1'b0);
      chk("bp_ready_low", bus.ready_out, 1'b0);
      @(posedge clk); #1;
    end
    bus.mem_full = 1'b0;
    #1;
    chk("wr_we_issue", bus.mem_we, 1'b1);
    @(posedge clk); #1;
    chk("wr_ready_back", bus.ready_out, 1'b1);
    chk("wr_count", n_we - w0, 1);
    if (both) begin
      repeat (3) @(posedge clk);
      #1;
      chk("both_no_read", n_re - r0, 0);
    end
  endtask

  task automatic do_read(input logic [26:0] a, input logic [127:0] line, input logic [24:0] ema,
                         input logic [15:0] emask, input logic [31:0] exp, input int delay,
                         input int nfull);
    cmd_t c;
    c.is_wr = 1'b0; c.maddr = ema; c.mask = emask; c.data = '0;
    cmd_q.push_back(c);
    rd_q.push_back(exp);
    chk("rd_ready_idle", bus.ready_out, 1'b1);
    bus.addr_in = a; bus.re_in = 1'b1;
    bus.mem_full = (nfull > 0);
    @(posedge clk); #1;
    bus.re_in = 1'b0;
    for (int i = 0; i < nfull; i++) begin
      chk("bp_re_low", bus.mem_re, 1'b0);
      @(posedge clk); #1;
    end
    bus.mem_full = 1'b0;
    #1;
    chk("rd_re_issue", bus.mem_re, 1'b1);
    @(posedge clk); #1;
    for (int i = 0; i < delay; i++) begin
      chk("rd_wait_quiet", {bus.mem_re, bus.ready_out, bus.dout_valid}, 3'b000);
      @(posedge clk); #1;
    end
    bus.mem_rdata = line; bus.mem_ravail = 1'b1;
    @(posedge clk); #1;
    bus.mem_ravail = 1'b0; bus.mem_rdata = '0;
    #1;
    chk("rd_dout_valid", bus.dout_valid, 1'b1);
    chk("rd_dout", bus.dout, exp);
    @(posedge clk); #1;
    chk("rd_valid_pulse", bus.dout_valid, 1'b0);
    chk("rd_dout_hold", bus.dout, exp);
    wait_ready();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int w0;
    vecs[0] = '{1'b1, 27'h0000006, 32'hDEADBEEF, '0, 0, 0, 25'h1, 16'h0F00, 32'h0};
    vecs[1] = '{1'b0, 27'h000000B, 32'h0, 128'h12345678_CAFEF00D_0BADBEEF_55AA55AA,
                5, 0, 25'h2, 16'hF000, 32'h12345678};
    vecs[2] = '{1'b1, 27'h0000000, 32'hA5A50001, '0, 0, 0, 25'h0, 16'h000F, 32'h0};
    vecs[3] = '{1'b1, 27'h7FFFFFF, 32'hFFFF0000, '0, 0, 4, 25'h1FFFFFF, 16'hF000, 32'h0};
    vecs[4] = '{1'b0, 27'h0000001, 32'h0, 128'h44444444_33333333_22222222_11111111,
                0, 2, 25'h0, 16'h00F0, 32'h22222222};
    vecs[5] = '{1'b0, 27'h0000010, 32'h0, 128'h44444444_33333333_22222222_11111111,
                1, 0, 25'h4, 16'h000F, 32'h11111111};
    vecs[6] = '{1'b0, 27'h0000012, 32'h0, 128'h44444444_33333333_22222222_11111111,
                2, 0, 25'h4, 16'h0F00, 32'h33333333};
    vecs[7] = '{1'b1, 27'h0000005, 32'h01234567, '0, 0, 0, 25'h1, 16'h00F0, 32'h0};

    bus.addr_in = '0; bus.din = '0; bus.we_in = 1'b0; bus.re_in = 1'b0;
    bus.mem_full = 1'b0; bus.mem_rdata = '0; bus.mem_ravail = 1'b0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_ready", bus.ready_out, 1'b1);
    chk("rst_we", bus.mem_we, 1'b0);
    chk("rst_re", bus.mem_re, 1'b0);
    chk("rst_dout", bus.dout, 32'h0);
    chk("rst_dout_valid", bus.dout_valid, 1'b0);
    @(posedge clk); #1;

    for (int i = 0; i < 8; i++) begin
      $display("vector %0d %s addr=%h", i, vecs[i].is_wr ? "write" : "read", vecs[i].addr);
      if (vecs[i].is_wr)
        do_write(vecs[i].addr, vecs[i].data, vecs[i].exp_maddr, vecs[i].exp_mask, vecs[i].nfull, 1'b0);
      else
        do_read(vecs[i].addr, vecs[i].line, vecs[i].exp_maddr, vecs[i].exp_mask,
                vecs[i].exp_dout, vecs[i].delay, vecs[i].nfull);
    end

    $display("sequence simultaneous strobes");
    do_write(27'h000000E, 32'h0F0F0F0F, 25'h3, 16'h0F00, 0, 1'b1);

    // Strobes outside IDLE must be ignored: fire one mid-write-backpressure.
    $display("sequence strobe while busy");
    begin
      cmd_t c;
      c.is_wr = 1'b1; c.maddr = 25'h5; c.mask = 16'h000F; c.data = 32'h600DF00D;
      cmd_q.push_back(c);
      w0 = n_we;
      bus.addr_in = 27'h14; bus.din = 32'h600DF00D; bus.we_in = 1'b1; bus.mem_full = 1'b1;
      @(posedge clk); #1;
      bus.addr_in = 27'h1B; bus.din = 32'hBAADBAAD; bus.re_in = 1'b1;
      @(posedge clk); #1;
      bus.we_in = 1'b0; bus.re_in = 1'b0; bus.mem_full = 1'b0;
      #1;
      chk("busy_we_issue", bus.mem_we, 1'b1);
      @(posedge clk); #1;
      repeat (2) @(posedge clk);
      #1;
      chk("busy_one_write", n_we - w0, 1);
    end

    $display("sequence reset mid-write");
    w0 = n_we;
    bus.addr_in = 27'h3; bus.din = 32'h11112222; bus.we_in = 1'b1; bus.mem_full = 1'b1;
    @(posedge clk); #1;
    bus.we_in = 1'b0;
    chk("mw_ready_low", bus.ready_out, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; bus.mem_full = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("mw_no_write", n_we - w0, 0);
    chk("mw_ready", bus.ready_out, 1'b1);

    $display("sequence reset mid-read");
    begin
      cmd_t c;
      c.is_wr = 1'b0; c.maddr = 25'h2; c.mask = 16'h00F0; c.data = '0;
      cmd_q.push_back(c);
      bus.addr_in = 27'h9; bus.re_in = 1'b1;
      @(posedge clk); #1;
      bus.re_in = 1'b0;
      chk("mr_re_issue", bus.mem_re, 1'b1);
      @(posedge clk); #1;
      chk("mr_in_wait", bus.ready_out, 1'b0);
      rst = 1'b1;
      #2;
      chk("mr_async_idle", bus.ready_out, 1'b1);
      @(posedge clk); #1;
      rst = 1'b0;
      bus.mem_rdata = {4{32'hFEEDFACE}}; bus.mem_ravail = 1'b1;
      @(posedge clk); #1;
      bus.mem_ravail = 1'b0; bus.mem_rdata = '0;
      #1;
      chk("mr_stray_valid", bus.dout_valid, 1'b0);
      chk("mr_stray_dout", bus.dout, 32'h0);
      chk("mr_idle", bus.ready_out, 1'b1);
    end
    do_write(27'h000000D, 32'hC0FFEE00, 25'h3, 16'h00F0, 0, 1'b0);
    do_read(27'h000000D, 128'hAAAAAAAA_BBBBBBBB_C0FFEE00_DDDDDDDD, 25'h3, 16'h00F0,
            32'hC0FFEE00, 3, 0);

    repeat (3) @(posedge clk);
    #1;
    chk("cmd_q_drained", cmd_q.size(), 0);
    chk("rd_q_drained", rd_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
